// File: rtl/if_inst_queue_if.sv
// Fetch-to-decode instruction queue handshake bundle.
// The queue takes the slave modport; the fetch/decode environment takes the master modport.
interface if_inst_queue_if #(
  parameter int unsigned AW = 64
);
  logic          in_valid;
  logic [AW-1:0] in_pc;
  logic [31:0]   in_inst;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [31:0]   out_inst;
  logic          out_ready;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/if_inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of {pc, inst} with flush.
// Define IF_IQ_BYPASS_EN to present an incoming beat combinationally when the queue is empty.
module if_inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  if_inst_queue_if.slave           q_if,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            empty;
  logic            push;
  logic            bypass;
  logic            wr_en;
  logic            rd_en;
  entry_t          head;

  always_comb begin
    empty         = (count_q == '0);
    q_if.in_ready = !rst && !flush && (count_q < CW'(DEPTH));
    push          = q_if.in_valid && q_if.in_ready;
    head          = mem_q[rd_ptr_q];

`ifdef IF_IQ_BYPASS_EN
    bypass = empty && !flush && !rst;
`else
    bypass = 1'b0;
`endif

    if (bypass) begin
      q_if.out_valid = q_if.in_valid;
      q_if.out_pc    = q_if.in_pc;
      q_if.out_inst  = q_if.in_inst;
    end else begin
      q_if.out_valid = !empty && !flush && !rst;
      q_if.out_pc    = q_if.out_valid ? head.pc   : '0;
      q_if.out_inst  = q_if.out_valid ? head.inst : '0;
    end

    // A bypassed beat consumed in the same cycle never touches storage.
    wr_en = push && !(bypass && q_if.out_ready);
    rd_en = q_if.out_valid && q_if.out_ready && !empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = '{pc: q_if.in_pc, inst: q_if.in_inst};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    count = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed bench for if_inst_queue: a queue scoreboard predicts every handshake output each cycle.
module tb_if_inst_queue;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  entry_t      sb[$];

  if_inst_queue_if #(.AW(64)) q_if ();

  if_inst_queue #(.DEPTH(4), .AW(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .q_if  (q_if),
    .flush (flush),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance the model.
  task automatic step(input logic iv, input logic [63:0] pc, input logic ordy,
                      input logic fl, input logic rs);
    logic        exp_ready;
    logic        exp_ov;
    logic        byp;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] inst;
    inst = pc[31:0] ^ 32'h0000_0013;
    @(negedge clk);
    q_if.in_valid  = iv;
    q_if.in_pc     = pc;
    q_if.in_inst   = inst;
    q_if.out_ready = ordy;
    flush          = fl;
    rst            = rs;
    #1;
    exp_ready = !rs && !fl && (sb.size() < 4);
    byp       = 1'b0;
`ifdef IF_IQ_BYPASS_EN
    byp = (sb.size() == 0) && !fl && !rs;
`endif
    if (byp) begin
      exp_ov   = iv;
      exp_pc   = pc;
      exp_inst = inst;
    end else begin
      exp_ov   = (sb.size() != 0) && !fl && !rs;
      exp_pc   = exp_ov ? sb[0].pc : 64'h0;
      exp_inst = exp_ov ? sb[0].inst : 32'h0;
    end
    check("in_ready", {63'h0, q_if.in_ready}, {63'h0, exp_ready});
    check("out_valid", {63'h0, q_if.out_valid}, {63'h0, exp_ov});
    check("out_pc", q_if.out_pc, exp_pc);
    check("out_inst", {32'h0, q_if.out_inst}, {32'h0, exp_inst});
    check("count", {61'h0, count}, 64'(sb.size()));
    if (rs || fl) begin
      sb.delete();
    end else begin
      if (exp_ov && ordy && !byp) void'(sb.pop_front());
      if (iv && exp_ready && !(byp && ordy)) sb.push_back('{pc: pc, inst: inst});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    q_if.in_valid  = 1'b0;
    q_if.in_pc     = '0;
    q_if.in_inst   = '0;
    q_if.out_ready = 1'b0;

    // Reset state.
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Three pushes held, then popped in order.
    for (int i = 0; i < 3; i++) step(1'b1, 64'(i * 4), 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    drain();

    // Fill to full; fifth beat refused, freed slot accepted the cycle after the pop.
    for (int i = 0; i < 4; i++) step(1'b1, 64'h10 + 64'(i * 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h20, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h20, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    drain();

    // Steady state at count=2 with simultaneous push and pop, wrapping pointers.
    step(1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h204, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 64'h208 + 64'(i * 4), 1'b1, 1'b0, 1'b0);
    drain();

    // Flush at count=3 beats a concurrent push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, 64'h300 + 64'(i * 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h40, 1'b1, 1'b1, 1'b0);
    step(1'b1, 64'h80, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    drain();

    // Reset mid-operation.
    step(1'b1, 64'h400, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h404, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h408, 1'b0, 1'b0, 1'b0);
    drain();

    // Empty queue with a beat offered and consumed immediately (bypass-dependent timing).
    step(1'b1, 64'h100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h104, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_inst_queue.md
IF_INST_QUEUE -- requirements
Module: if_inst_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 SHALL provide parameter AW, default 64, PC width, matching REG_BUS.
REQ-003 SHALL provide port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port in_valid  input  1  fetch side holds a fetched instruction.
REQ-006 SHALL provide port in_pc  input  AW  address of the fetched instruction (fetch-stage inst_addr).
REQ-007 SHALL provide port in_inst  input  32  fetched instruction word.
REQ-008 SHALL provide port in_ready  output  1  queue accepts an entry this cycle.
REQ-009 SHALL provide port out_valid  output  1  head entry available to decode.
REQ-010 SHALL provide port out_pc  output  AW  head entry PC.
REQ-011 SHALL provide port out_inst  output  32  head entry instruction.
REQ-012 SHALL provide port out_ready  input  1  decode consumes the head this cycle.
REQ-013 SHALL provide port flush  input  1  redirect (taken branch/jump); discard all entries.
REQ-014 SHALL provide port count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL be a FIFO: push = in_valid & in_ready, pop = out_valid & out_ready; entries leave in arrival order.
REQ-016 SHALL drive in_ready = !rst & !flush & (count < DEPTH); combinational, not dependent on out_ready.
REQ-017 SHALL drive out_valid = (count != 0) & !flush; out_pc/out_inst = head entry when out_valid, else all zeros.
REQ-018 SHALL make a pushed entry visible at out_valid one cycle after the push cycle (latency 1, no bypass).
REQ-019 SHALL update count by +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
REQ-020 SHALL wrap read/write pointers modulo DEPTH; a full queue with a pop SHALL accept no push in that same cycle.
REQ-021 SHALL give flush priority over push and pop: in the flush cycle no entry is written or consumed; count = 0 and both pointers = 0 on the next edge.
REQ-022 SHALL never change a stored entry's pc/inst while the entry remains in the queue.
REQ-023 SHALL keep out_valid, out_pc and out_inst stable while out_valid=1 and out_ready=0, absent flush.

Reset
REQ-024 SHALL, with rst high at a rising edge, set count=0 and both pointers=0; out_valid=0, in_ready=0 and out_pc/out_inst=0 while rst is high.
REQ-025 SHALL discard all entries on rst asserted mid-operation; storage contents need no clearing.

Configuration
REQ-026 SHALL recognise macro IF_IQ_BYPASS_EN; when undefined, behaviour is exactly REQ-015..REQ-023.
REQ-027 SHALL, with IF_IQ_BYPASS_EN defined, when count=0 and no flush: out_valid = in_valid, out_pc/out_inst = in_pc/in_inst combinationally.
REQ-028 SHALL, with IF_IQ_BYPASS_EN defined and a bypassed beat where out_ready=1, not store the entry (count stays 0); where out_ready=0, store it normally so the same data is presented next cycle.

Verification
REQ-029 SHALL cover: push pc=0x0,0x4,0x8 with inst 0x00000013 and out_ready=0 -> count=3, then out_ready=1 -> pops pc 0x0,0x4,0x8 in order, count returns to 0.
REQ-030 SHALL cover: push 4 entries with out_ready=0 -> in_ready=0 at count=4; a fifth in_valid beat is not accepted; one pop -> in_ready=1 on the following cycle.
REQ-031 SHALL cover: count=2, in_valid=1 and out_ready=1 for 10 cycles, pc stepping by 4 -> count stays 2, output pc sequence equals input sequence delayed by 2 entries, pointers wrap cleanly.
REQ-032 SHALL cover: count=3 and flush=1 together with in_valid=1 and out_ready=1 -> no pop, no push; next cycle count=0, out_valid=0; a push of pc=0x80 then appears at out_pc=0x80.
REQ-033 SHALL cover: rst asserted with count=2 -> next cycle count=0, out_valid=0, in_ready=0; after rst deasserts, in_ready=1.
REQ-034 SHALL cover, with IF_IQ_BYPASS_EN: empty queue, in_valid=1, in_pc=0x100, out_ready=1 -> out_valid=1 and out_pc=0x100 in the same cycle, count stays 0; without the macro, out_valid rises one cycle later.
